// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter and its three requesters plus the shared single-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              ldReq;
  logic [ADDR_W-1:0] ldAddr;
  logic [DATA_W-1:0] ldWdata;
  logic              ldAck;

  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifAck;

  logic              lsReq;
  logic              lsWe;
  logic [ADDR_W-1:0] lsAddr;
  logic [DATA_W-1:0] lsWdata;
  logic [BE_W-1:0]   lsBe;
  logic              lsAck;

  logic [DATA_W-1:0] rdata;

  logic              memEn;
  logic [BE_W-1:0]   memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  logic              memWait;

  modport slave (
    input  ldReq, ldAddr, ldWdata, ifReq, ifAddr,
    input  lsReq, lsWe, lsAddr, lsWdata, lsBe, memRdata,
    output ldAck, ifAck, lsAck, rdata,
    output memEn, memWe, memAddr, memWdata, memWait
  );

  modport master (
    output ldReq, ldAddr, ldWdata, ifReq, ifAddr,
    output lsReq, lsWe, lsAddr, lsWdata, lsBe, memRdata,
    input  ldAck, ifAck, lsAck, rdata,
    input  memEn, memWe, memAddr, memWdata, memWait
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-way arbiter (loader > load/store > fetch) onto one single-port RAM, one transaction in flight.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch outrank load/store after STARVE_LIM denials.
module mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 3
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {OWN_LD, OWN_LS, OWN_IF} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [BE_W-1:0]   we_q, we_d;
  logic              wr_q, wr_d;
  logic              ld_ack_q, ld_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic              if_ack_q, if_ack_d;
  logic              grant_ld, grant_ls, grant_if;
  logic              if_wins;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign if_wins = bus.ifReq && (cnt_q >= LIM);

  // Count load/store grants that pass over a waiting fetch; saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_if) begin
      cnt_d = '0;
    end else if (grant_ls && bus.ifReq && (cnt_q < LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign if_wins = (STARVE_LIM < 0);
`endif

  // Arbitration only happens in IDLE, so requests arriving mid-transaction wait their turn.
  always_comb begin
    grant_ld = 1'b0;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (state_q == IDLE) begin
      if (bus.ldReq) begin
        grant_ld = 1'b1;
      end else if (if_wins) begin
        grant_if = 1'b1;
      end else if (bus.lsReq) begin
        grant_ls = 1'b1;
      end else if (bus.ifReq) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    ld_ack_d = 1'b0;
    ls_ack_d = 1'b0;
    if_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ld) begin
          owner_d = OWN_LD;
          addr_d  = bus.ldAddr;
          wdata_d = bus.ldWdata;
          we_d    = '1;
          wr_d    = 1'b1;
          state_d = ACCESS;
        end else if (grant_ls) begin
          owner_d = OWN_LS;
          addr_d  = bus.lsAddr;
          wdata_d = bus.lsWdata;
          we_d    = bus.lsWe ? bus.lsBe : '0;
          wr_d    = bus.lsWe;
          state_d = ACCESS;
        end else if (grant_if) begin
          owner_d = OWN_IF;
          addr_d  = bus.ifAddr;
          we_d    = '0;
          wr_d    = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (!wr_q) begin
          rdata_d = bus.memRdata;
        end
        ld_ack_d = (owner_q == OWN_LD);
        ls_ack_d = (owner_q == OWN_LS);
        if_ack_d = (owner_q == OWN_IF);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_LD;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      ld_ack_q <= 1'b0;
      ls_ack_q <= 1'b0;
      if_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      ld_ack_q <= ld_ack_d;
      ls_ack_q <= ls_ack_d;
      if_ack_q <= if_ack_d;
    end
  end

  assign bus.memEn    = (state_q == ACCESS);
  assign bus.memWe    = (state_q == ACCESS) ? we_q : '0;
  assign bus.memAddr  = addr_q;
  assign bus.memWdata = wdata_q;
  assign bus.rdata    = rdata_q;
  assign bus.ldAck    = ld_ack_q;
  assign bus.lsAck    = ls_ack_q;
  assign bus.ifAck    = if_ack_q;
  assign bus.memWait  = bus.lsReq && !ls_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus multi-cycle sequences.
// Expectations for the starvation sequence follow MEM_ARB_STARVE_GUARD_EN as compiled.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(14), .DATA_W(32), .STARVE_LIM(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Single-port RAM model: registered read, byte-enabled write.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (bus.memEn) begin
      if (bus.memWe == 4'b0000) begin
        bus.memRdata <= ram[bus.memAddr[7:0]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.memWe[b]) ram[bus.memAddr[7:0]][8*b +: 8] <= bus.memWdata[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    int          who;       // 0 loader, 1 load/store, 2 fetch
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  exp_memwe;
    logic [2:0]  exp_ack;   // {ld, ls, if}
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [0:8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic drop_all();
    bus.ldReq = 1'b0;
    bus.lsReq = 1'b0;
    bus.ifReq = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    case (v.who)
      0: begin bus.ldReq = 1'b1; bus.ldAddr = v.addr; bus.ldWdata = v.wdata; end
      1: begin
        bus.lsReq = 1'b1; bus.lsWe = v.we; bus.lsAddr = v.addr;
        bus.lsWdata = v.wdata; bus.lsBe = v.be;
      end
      default: begin bus.ifReq = 1'b1; bus.ifAddr = v.addr; end
    endcase
    @(posedge clk); #1;
    chk($sformatf("v%0d memEn", i), 32'(bus.memEn), 32'd1);
    chk($sformatf("v%0d memWe", i), 32'(bus.memWe), 32'(v.exp_memwe));
    chk($sformatf("v%0d memAddr", i), 32'(bus.memAddr), 32'(v.addr));
    @(posedge clk); #1;
    chk($sformatf("v%0d early_ack", i), 32'({bus.ldAck, bus.lsAck, bus.ifAck}), 32'd0);
    chk($sformatf("v%0d memEn_off", i), 32'(bus.memEn), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d acks", i), 32'({bus.ldAck, bus.lsAck, bus.ifAck}), 32'(v.exp_ack));
    chk($sformatf("v%0d rdata", i), bus.rdata, v.exp_rdata);
    $display("txn %0d who=%0d we=%0b addr=0x%03h rdata=0x%08h", i, v.who, v.we, v.addr, bus.rdata);
    drop_all();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = 32'h0;
    ram[8'h10] = 32'h00000013;
    ram[8'h20] = 32'h11223344;
    drop_all();
    bus.ldAddr = '0; bus.ldWdata = '0; bus.ifAddr = '0;
    bus.lsWe = 1'b0; bus.lsAddr = '0; bus.lsWdata = '0; bus.lsBe = '0;

    vecs[0] = '{2, 1'b0, 14'h010, 32'h0,        4'h0, 4'h0, 3'b001, 32'h00000013};
    vecs[1] = '{1, 1'b1, 14'h020, 32'hAABBCCDD, 4'h3, 4'h3, 3'b010, 32'h00000013};
    vecs[2] = '{1, 1'b0, 14'h020, 32'h0,        4'hF, 4'h0, 3'b010, 32'h1122CCDD};
    vecs[3] = '{0, 1'b1, 14'h030, 32'hDEADBEEF, 4'h0, 4'hF, 3'b100, 32'h1122CCDD};
    vecs[4] = '{2, 1'b0, 14'h030, 32'h0,        4'h0, 4'h0, 3'b001, 32'hDEADBEEF};
    vecs[5] = '{1, 1'b1, 14'h030, 32'h12345678, 4'hC, 4'hC, 3'b010, 32'hDEADBEEF};
    vecs[6] = '{1, 1'b0, 14'h030, 32'h0,        4'h0, 4'h0, 3'b010, 32'h1234BEEF};
    vecs[7] = '{0, 1'b1, 14'h040, 32'h00000000, 4'h0, 4'hF, 3'b100, 32'h1234BEEF};
    vecs[8] = '{2, 1'b0, 14'h040, 32'h0,        4'h0, 4'h0, 3'b001, 32'h00000000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_acks", 32'({bus.ldAck, bus.lsAck, bus.ifAck}), 32'd0);
    chk("rst_memEn", 32'(bus.memEn), 32'd0);
    chk("rst_memWe", 32'(bus.memWe), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i);
    repeat (2) @(posedge clk);
    #1;

    // Loader and load/store together: loader first, load/store waits one full slot.
    bus.ldReq = 1'b1; bus.ldAddr = 14'h050; bus.ldWdata = 32'hCAFEF00D;
    bus.lsReq = 1'b1; bus.lsWe = 1'b0; bus.lsAddr = 14'h010; bus.lsBe = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("pri k%0d ldAck", k), 32'(bus.ldAck), 32'(k == 2));
      chk($sformatf("pri k%0d lsAck", k), 32'(bus.lsAck), 32'(k == 5));
      chk($sformatf("pri k%0d memWait", k), 32'(bus.memWait), 32'(k < 5));
      if (k == 0) chk("pri ld memWe", 32'(bus.memWe), 32'hF);
      if (k == 3) chk("pri ls memAddr", 32'(bus.memAddr), 32'h010);
      if (k == 5) chk("pri ls rdata", bus.rdata, 32'h00000013);
      if (k == 2) bus.ldReq = 1'b0;
      if (k == 5) bus.lsReq = 1'b0;
    end
    $display("txn pri ld+ls done");

    // Fetch drops its request right after the grant; it still completes.
    bus.ifReq = 1'b1; bus.ifAddr = 14'h050;
    @(posedge clk); #1;
    bus.ifReq = 1'b0;
    chk("drop memEn", 32'(bus.memEn), 32'd1);
    @(posedge clk); #1;
    chk("drop early", 32'(bus.ifAck), 32'd0);
    @(posedge clk); #1;
    chk("drop ifAck", 32'(bus.ifAck), 32'd1);
    chk("drop rdata", bus.rdata, 32'hCAFEF00D);
    $display("txn drop-after-grant rdata=0x%08h", bus.rdata);
    repeat (2) @(posedge clk);
    #1;

    // Reset while in ACCESS aborts the load; the held request is granted again.
    bus.lsReq = 1'b1; bus.lsWe = 1'b0; bus.lsAddr = 14'h020;
    @(posedge clk); #1;
    chk("rstacc memEn", 32'(bus.memEn), 32'd1);
    rst = 1'b1;
    for (int k = 1; k < 7; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        rst = 1'b0;
        chk("rstacc rdata", bus.rdata, 32'd0);
      end
      chk($sformatf("rstacc k%0d lsAck", k), 32'(bus.lsAck), 32'(k == 4));
      chk($sformatf("rstacc k%0d memEn", k), 32'(bus.memEn), 32'(k == 2));
      if (k == 4) begin
        chk("rstacc regrant rdata", bus.rdata, 32'h1122CCDD);
        bus.lsReq = 1'b0;
      end
    end
    $display("txn reset-in-access done");
    repeat (2) @(posedge clk);
    #1;

    // Fetch and load/store both held continuously.
    bus.lsReq = 1'b1; bus.lsWe = 1'b0; bus.lsAddr = 14'h010;
    bus.ifReq = 1'b1; bus.ifAddr = 14'h020;
    for (int k = 0; k < 15; k++) begin
      logic exp_ls, exp_if;
      @(posedge clk); #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_ls = (k == 2) || (k == 5) || (k == 8) || (k == 14);
      exp_if = (k == 11);
`else
      exp_ls = ((k % 3) == 2);
      exp_if = 1'b0;
`endif
      chk($sformatf("starve k%0d lsAck", k), 32'(bus.lsAck), 32'(exp_ls));
      chk($sformatf("starve k%0d ifAck", k), 32'(bus.ifAck), 32'(exp_if));
      if (exp_if) chk("starve if rdata", bus.rdata, 32'h1122CCDD);
      if (exp_ls) chk($sformatf("starve k%0d ls rdata", k), bus.rdata, 32'h00000013);
    end
    drop_all();
    $display("txn starvation sequence done");
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 14, word-address width of the shared memory port.
REQ-002 Parameter DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_LIM, 3, consecutive fetch denials before fetch is promoted.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 ldReq/ldAddr/ldWdata  input  1/ADDR_W/DATA_W  program-loader word write request.
REQ-007 ldAck  output  1  one-cycle pulse: loader write done.
REQ-008 ifReq/ifAddr  input  1/ADDR_W  instruction-fetch read request.
REQ-009 ifAck  output  1  one-cycle pulse: rdata holds the fetch word.
REQ-010 lsReq/lsWe/lsAddr/lsWdata/lsBe  input  1/1/ADDR_W/DATA_W/DATA_W/8  load/store request.
REQ-011 lsAck  output  1  one-cycle pulse: store done, or rdata holds the load word.
REQ-012 rdata  output  DATA_W  registered read return, shared by fetch and load/store.
REQ-013 memEn/memWe/memAddr/memWdata  output  1/DATA_W/8/ADDR_W/DATA_W  single-port RAM drive.
REQ-014 memRdata  input  DATA_W  RAM read data, valid one cycle after memEn.
REQ-015 memWait  output  1  load/store stall to the mode FSM.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-017 IDLE: a request sampled high at edge N selects owner -> ACCESS; memEn=1 for exactly the cycle after N.
REQ-018 ACCESS -> RESP unconditionally; RESP: rdata<=memRdata on reads, owner's ack pulses high for one cycle after that, -> IDLE.
REQ-019 Latency: request seen at edge N -> ack high in cycle N+2; back-to-back grants need 3 cycles each.
REQ-020 Priority: ldReq > lsReq > ifReq; simultaneous requests resolved only in IDLE.
REQ-021 Requesters hold req and payload stable until ack; arbiter latches owner, address, data, we, be at grant.
REQ-022 Requester dropping req after grant does not abort; transaction completes and ack still pulses.
REQ-023 Loader writes use memWe all ones; ls stores use memWe=lsBe; all reads use memWe=0.
REQ-024 rdata holds its last value outside RESP and after write transactions.
REQ-025 memWait = lsReq AND NOT lsAck, combinational; low in the lsAck cycle.
REQ-026 Ack outputs mutually exclusive; no ack without a preceding grant.

Reset
REQ-027 rst forces IDLE, all acks 0, memEn 0, memWe 0, rdata 0, starvation counter 0.
REQ-028 rst during ACCESS or RESP aborts the transaction; its ack never pulses.
REQ-029 rst has priority over every other state transition.

Configuration
REQ-030 Macro MEM_ARB_STARVE_GUARD_EN defined: counter increments per grant to ls while ifReq high, clears on if grant; at STARVE_LIM, if outranks ls (never outranks ld).
REQ-031 Macro undefined: strict fixed priority per REQ-020; counter absent.

Verification
REQ-032 ifReq alone, addr 0x010, RAM word 0x00000013 -> memEn at N+1, ifAck and rdata=0x00000013 at N+2.
REQ-033 ldReq and lsReq both high at N -> ld granted first (ldAck N+2), lsAck N+5; memWait high N..N+4.
REQ-034 lsWe=1, lsBe=0011, wdata 0xAABBCCDD onto 0x11223344 -> later read returns 0x1122CCDD.
REQ-035 lsReq held and ifReq held, guard enabled, STARVE_LIM=3 -> 3 ls grants, then 1 if grant; guard disabled -> if never granted.
REQ-036 rst pulsed in ACCESS -> no ack, state IDLE, memEn 0 next cycle; request still high re-granted afterwards.
